// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the instruction-memory port and the decode-side
// valid/ready handshake of the fetch stage.
//
// Handshake: the fetch side drives instr_valid_o/instr_o/instr_pc_o from
// registered state only. The consumer drives instr_ready_i. A word is
// transferred on a rising edge where instr_valid_o && instr_ready_i. While
// instr_valid_o is high and instr_ready_i is low, the head word and its pc
// stay stable. instr_valid_o never depends on instr_ready_i in the same cycle.
interface fetch_unit_if;
    logic [31:0] pc_o;           // fetch address to instruction memory
    logic [31:0] instr_i;        // instruction word returned for pc_o
    logic        redirect_i;     // branch/jump taken
    logic [31:0] redirect_pc_i;  // redirect target, low two bits ignored
    logic [31:0] instr_o;        // buffer head instruction
    logic [31:0] instr_pc_o;     // address the head was fetched from
    logic        instr_valid_o;  // buffer head is valid
    logic        instr_ready_i;  // consumer accepts head this cycle

    // Fetch stage side
    modport master (
        output pc_o,
        input  instr_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_o,
        output instr_pc_o,
        output instr_valid_o,
        input  instr_ready_i
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  pc_o,
        output instr_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_o,
        input  instr_pc_o,
        input  instr_valid_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, presents it to the
// instruction memory, buffers returned words in a 2-entry FIFO and offers
// them to decode with valid/ready. Redirects flush the FIFO and reload the PC.
//
// Optional feature macro: FETCH_PERF_EN adds stall_count_o, a wrapping count
// of edges where the head was valid but not accepted.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_count_o
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_instr [2];
    logic [31:0] r_ipc   [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_valid;
    logic        w_pop;
    logic        w_push;

    // Valid and head data come only from registers; ready only steers push.
    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && bus.instr_ready_i;
    assign w_push  = !bus.redirect_i && ((r_count != 2'd2) || w_pop);

    assign bus.pc_o          = r_pc;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = r_instr[r_rd_ptr];
    assign bus.instr_pc_o    = r_ipc[r_rd_ptr];

    // PC and FIFO update: redirect flushes and reloads, otherwise push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_instr[0] <= 32'd0;
            r_instr[1] <= 32'd0;
            r_ipc[0]   <= 32'd0;
            r_ipc[1]   <= 32'd0;
        end else if (bus.redirect_i) begin
            // A same-cycle pop is simply dropped along with the flush.
            r_pc     <= {bus.redirect_pc_i[31:2], 2'b00};
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= bus.instr_i;
                r_ipc[r_wr_ptr]   <= r_pc;
                r_wr_ptr          <= ~r_wr_ptr;
                r_pc              <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_count;

    // Backpressure counter: survives redirects, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 32'd0;
        end else if (w_valid && !bus.instr_ready_i) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count_o = r_stall_count;
`endif

endmodule
